// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mont_exp_ctrl                                                        |
// | Left-to-right binary exponentiation sequencer driving an external    |
// | Montgomery multiplier.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mont_exp_ctrl #(
  parameter int WIDTH  = 1024,
  parameter int E_BITS = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [E_BITS-1:0] in_e,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_r,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              mul_start,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic [WIDTH-1:0]  mul_m,
  input  logic [WIDTH-1:0]  mul_result,
  input  logic              mul_done
);

  localparam int IDX_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [IDX_W-1:0] C_I_TOP = IDX_W'(E_BITS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SQ_ISSUE  = 3'd1;
  localparam logic [2:0] ST_SQ_WAIT   = 3'd2;
  localparam logic [2:0] ST_MUL_ISSUE = 3'd3;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  logic [2:0]        state_q,  state_d;
  logic [WIDTH-1:0]  a_q,      a_d;
  logic [WIDTH-1:0]  x_q,      x_d;
  logic [WIDTH-1:0]  m_q,      m_d;
  logic [E_BITS-1:0] e_q,      e_d;
  logic [IDX_W-1:0]  i_q,      i_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              w_bit;

  assign w_bit = e_q[i_q];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    x_d      = x_q;
    m_d      = m_q;
    e_d      = e_q;
    i_d      = i_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          a_d     = in_r;
          i_d     = C_I_TOP;
          state_d = ST_SQ_ISSUE;
        end
      end
      ST_SQ_ISSUE:  state_d = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mul_done) begin
          a_d = mul_result;
          if (w_bit) begin
            state_d = ST_MUL_ISSUE;
          end else if (i_q != '0) begin
            i_d     = i_q - 1'b1;
            state_d = ST_SQ_ISSUE;
          end else begin
            // Load result early so it is already valid while done is high.
            result_d = mul_result;
            state_d  = ST_FINISH;
          end
        end
      end
      ST_MUL_ISSUE: state_d = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_done) begin
          a_d = mul_result;
          if (i_q != '0) begin
            i_d     = i_q - 1'b1;
            state_d = ST_SQ_ISSUE;
          end else begin
            result_d = mul_result;
            state_d  = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        result_d = a_q;
        state_d  = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      x_q      <= '0;
      m_q      <= '0;
      e_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      x_q      <= x_d;
      m_q      <= m_d;
      e_q      <= e_d;
      i_q      <= i_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign done      = (state_q == ST_FINISH);
  assign mul_start = (state_q == ST_SQ_ISSUE) || (state_q == ST_MUL_ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = ((state_q == ST_MUL_ISSUE) || (state_q == ST_MUL_WAIT)) ? x_q : a_q;
  assign mul_m     = m_q;

endmodule
`default_nettype wire
